// File: rtl/f_pc_pkg.sv
// Shared encodings and defaults for the F-stage PC sequencer (f_pc_seq).
package f_pc_pkg;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BR   = 2'd1;
  localparam logic [1:0] BR_J    = 2'd2;
  localparam logic [1:0] BR_JR   = 2'd3;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_HI  = 32'h0000_6FFC;

  // True when the D-stage control-transfer type changes the fetch stream.
  function automatic logic is_redirect(input logic [1:0] br_type, input logic br_taken);
    return (br_type == BR_J) || (br_type == BR_JR) || ((br_type == BR_BR) && br_taken);
  endfunction

endpackage

// File: rtl/f_pc_seq_tgt_mux.sv
// Redirect target selection for the F-stage PC sequencer, keyed on the D-stage branch type.
module pc_tgt_mux
  import f_pc_pkg::*;
(
  input  logic [1:0]  br_type,
  input  logic [31:0] imm16_ext,
  input  logic [31:0] imm26_ext,
  input  logic [31:0] rs_data,
  output logic [31:0] target
);

  always_comb begin
    target = imm16_ext;
    case (br_type)
      BR_BR:   target = imm16_ext;
      BR_J:    target = imm26_ext;
      BR_JR:   target = rs_data;
      default: target = imm16_ext;
    endcase
  end

endmodule

// File: rtl/f_pc_seq.sv
// Fetch-stage PC sequencer with delay-slot handling and a pending-redirect hold.
// Optional fetch address checking is enabled by defining PC_ALIGN_CHK_EN.
module f_pc_seq
  import f_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] IMEM_LO  = DEF_IMEM_LO,
  parameter logic [31:0] IMEM_HI  = DEF_IMEM_HI
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        D_stall,
  input  logic        D_valid,
  input  logic [1:0]  D_br_type,
  input  logic        D_br_taken,
  input  logic [31:0] D_imm16_EXT,
  input  logic [31:0] D_imm26_EXT,
  input  logic [31:0] D_rs_data,
  input  logic        I_ready,
  output logic [31:0] F_pc,
  output logic        F_req,
  output logic        F_valid,
  output logic        F_exc_adel
);

  pc_state_t   state;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic [31:0] target;
  logic        fetch_done;
  logic        redir;

  if ((IMEM_LO > IMEM_HI) || (IMEM_LO[1:0] != 2'b00) || (IMEM_HI[1:0] != 2'b00)) begin : g_bad_range
    $error("f_pc_seq: IMEM_LO/IMEM_HI must be word aligned with IMEM_LO <= IMEM_HI");
  end

  pc_tgt_mux u_tgt_mux (
    .br_type   (D_br_type),
    .imm16_ext (D_imm16_EXT),
    .imm26_ext (D_imm26_EXT),
    .rs_data   (D_rs_data),
    .target    (target)
  );

  assign F_pc       = pc_q;
  assign F_req      = (state != RST);
  assign fetch_done = F_req & I_ready & ~D_stall;
  assign F_valid    = fetch_done;
  assign redir      = D_valid & ~D_stall & is_redirect(D_br_type, D_br_taken);

`ifdef PC_ALIGN_CHK_EN
  assign F_exc_adel = F_req & ((pc_q[1:0] != 2'b00) | (pc_q < IMEM_LO) | (pc_q > IMEM_HI));
`else
  assign F_exc_adel = 1'b0;
`endif

  // A redirect whose delay slot has not been fetched yet parks its target in tgt_q;
  // later redirects are ignored until that slot is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RST;
      pc_q  <= RESET_PC;
      tgt_q <= 32'h0;
    end else begin
      case (state)
        RST: state <= RUN;
        RUN: begin
          if (redir && fetch_done) begin
            pc_q <= target;
          end else if (redir) begin
            tgt_q <= target;
            state <= PEND;
          end else if (fetch_done) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        PEND: begin
          if (fetch_done) begin
            pc_q  <= tgt_q;
            state <= RUN;
          end
        end
        default: state <= RST;
      endcase
    end
  end

endmodule

// File: tb/tb_f_pc_seq.sv
// Self-checking bench for f_pc_seq: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_f_pc_seq;
  import f_pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        D_stall;
  logic        D_valid;
  logic [1:0]  D_br_type;
  logic        D_br_taken;
  logic [31:0] D_imm16_EXT;
  logic [31:0] D_imm26_EXT;
  logic [31:0] D_rs_data;
  logic        I_ready;
  logic [31:0] F_pc;
  logic        F_req;
  logic        F_valid;
  logic        F_exc_adel;

  int pass_count  = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  f_pc_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .D_stall     (D_stall),
    .D_valid     (D_valid),
    .D_br_type   (D_br_type),
    .D_br_taken  (D_br_taken),
    .D_imm16_EXT (D_imm16_EXT),
    .D_imm26_EXT (D_imm26_EXT),
    .D_rs_data   (D_rs_data),
    .I_ready     (I_ready),
    .F_pc        (F_pc),
    .F_req       (F_req),
    .F_valid     (F_valid),
    .F_exc_adel  (F_exc_adel)
  );

  typedef struct {
    logic        stall;
    logic        dvalid;
    logic [1:0]  br_type;
    logic        taken;
    logic [31:0] imm16;
    logic [31:0] imm26;
    logic [31:0] rs;
    logic        ready;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic        exp_valid;
  } vec_t;

  function automatic vec_t mk(input logic stall, input logic dvalid, input logic [1:0] br_type,
                              input logic taken, input logic [31:0] imm16, input logic [31:0] imm26,
                              input logic [31:0] rs, input logic ready, input logic [31:0] exp_pc,
                              input logic exp_req, input logic exp_valid);
    vec_t v;
    v.stall = stall;   v.dvalid = dvalid; v.br_type = br_type; v.taken = taken;
    v.imm16 = imm16;   v.imm26 = imm26;   v.rs = rs;           v.ready = ready;
    v.exp_pc = exp_pc; v.exp_req = exp_req; v.exp_valid = exp_valid;
    return v;
  endfunction

  // Address error expected on a requested fetch outside the word-aligned window.
  function automatic logic exp_exc(input logic req, input logic [31:0] pc);
    logic bad;
    bad = req && ((pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC));
`ifdef PC_ALIGN_CHK_EN
    return bad;
`else
    return 1'b0 && bad;
`endif
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_pc, input logic exp_req,
                             input logic exp_valid);
    checkVal({tag, " F_pc"}, F_pc, exp_pc);
    checkVal({tag, " F_req"}, {31'b0, F_req}, {31'b0, exp_req});
    checkVal({tag, " F_valid"}, {31'b0, F_valid}, {31'b0, exp_valid});
    checkVal({tag, " F_exc_adel"}, {31'b0, F_exc_adel}, {31'b0, exp_exc(exp_req, exp_pc)});
  endtask

  task automatic drive(input vec_t v);
    D_stall = v.stall;   D_valid = v.dvalid; D_br_type = v.br_type; D_br_taken = v.taken;
    D_imm16_EXT = v.imm16; D_imm26_EXT = v.imm26; D_rs_data = v.rs; I_ready = v.ready;
  endtask

  // Called at a negedge: drive one cycle, check mid-cycle, advance to the next negedge.
  task automatic applyStimulus(input string tag, input vec_t v);
    drive(v);
    #1;
    checkOutput(tag, v.exp_pc, v.exp_req, v.exp_valid);
    @(negedge clk);
  endtask

  vec_t vecs[14];

  // Reference model: fetch address, started flag, and a queue of targets due after a delay slot.
  logic [31:0] m_pc;
  logic        m_run;
  logic [31:0] m_due[$];

  function automatic logic [31:0] rand_target();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'hFFFF_FFFC;
    if (sel == 1) return $urandom();
    return {$urandom_range(32'h0000_0C00, 32'h0000_1BFF), 2'b00};
  endfunction

  initial begin
    vec_t v;
    vec_t nop_rdy;
    logic        r_stall, r_valid, r_taken, r_ready, done;
    logic [1:0]  r_type;
    logic [31:0] r16, r26, rrs, tgt;

    reset_n = 1'b0;
    drive(mk(0, 0, BR_NONE, 0, 0, 0, 0, 1, 0, 0, 0));
    nop_rdy = mk(0, 0, BR_NONE, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 checkOutput("reset", 32'h3000, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    vecs[0]  = mk(0, 0, BR_NONE, 0, 0,       0,       0,       1, 32'h3000, 0, 0);
    vecs[1]  = mk(0, 0, BR_NONE, 0, 0,       0,       0,       1, 32'h3000, 1, 1);
    vecs[2]  = mk(0, 0, BR_NONE, 0, 0,       0,       0,       1, 32'h3004, 1, 1);
    vecs[3]  = mk(0, 1, BR_BR,   1, 32'h3040, 0,      0,       1, 32'h3008, 1, 1);
    vecs[4]  = mk(0, 0, BR_NONE, 0, 0,       0,       0,       1, 32'h3040, 1, 1);
    vecs[5]  = mk(0, 1, BR_BR,   0, 32'h3200, 0,      0,       1, 32'h3044, 1, 1);
    vecs[6]  = mk(0, 0, BR_NONE, 0, 0,       0,       0,       1, 32'h3048, 1, 1);
    vecs[7]  = mk(0, 1, BR_JR,   0, 0,       0,       32'h3002, 1, 32'h304C, 1, 1);
    vecs[8]  = mk(0, 0, BR_NONE, 0, 0,       0,       0,       1, 32'h3002, 1, 1);
    vecs[9]  = mk(0, 1, BR_JR,   0, 0,       0,       32'h3050, 1, 32'h3006, 1, 1);
    vecs[10] = mk(0, 0, BR_J,    0, 0,       32'h3100, 0,      1, 32'h3050, 1, 1);
    vecs[11] = mk(0, 0, BR_NONE, 0, 0,       0,       0,       0, 32'h3054, 1, 0);
    vecs[12] = mk(0, 0, BR_NONE, 0, 0,       0,       0,       1, 32'h3054, 1, 1);
    vecs[13] = mk(0, 0, BR_NONE, 0, 0,       0,       0,       1, 32'h3058, 1, 1);
    for (int i = 0; i < 14; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Slow delay-slot fetch: J parks its target; a later JR in PEND must be ignored.
    applyStimulus("pend0", mk(0, 1, BR_J,  0, 0, 32'h3100, 0,        0, 32'h305C, 1, 0));
    applyStimulus("pend1", mk(0, 1, BR_JR, 0, 0, 0,        32'h3200, 0, 32'h305C, 1, 0));
    applyStimulus("pend2", mk(0, 1, BR_JR, 0, 0, 0,        32'h3200, 0, 32'h305C, 1, 0));
    applyStimulus("pend3", mk(0, 1, BR_JR, 0, 0, 0,        32'h3200, 1, 32'h305C, 1, 1));
    applyStimulus("pend4", nop_rdy.exp_pc == 0 ? mk(0, 0, BR_NONE, 0, 0, 0, 0, 1, 32'h3100, 1, 1) : nop_rdy);

    // Stall with a taken branch in D: nothing moves until the stall drops.
    applyStimulus("stall0", mk(1, 1, BR_BR, 1, 32'h3300, 0, 0, 1, 32'h3104, 1, 0));
    applyStimulus("stall1", mk(1, 1, BR_BR, 1, 32'h3300, 0, 0, 1, 32'h3104, 1, 0));
    applyStimulus("stall2", mk(0, 1, BR_BR, 1, 32'h3300, 0, 0, 1, 32'h3104, 1, 1));
    applyStimulus("stall3", mk(0, 0, BR_NONE, 0, 0, 0, 0, 1, 32'h3300, 1, 1));

    // Reset in PEND: the parked target must never be fetched.
    applyStimulus("rpend0", mk(0, 1, BR_J, 0, 0, 32'h3400, 0, 0, 32'h3304, 1, 0));
    drive(mk(0, 0, BR_NONE, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 checkOutput("rpend1", 32'h3304, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 checkOutput("rpend_async", 32'h3000, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("rpend2", mk(0, 0, BR_NONE, 0, 0, 0, 0, 1, 32'h3000, 0, 0));
    applyStimulus("rpend3", mk(0, 0, BR_NONE, 0, 0, 0, 0, 1, 32'h3000, 1, 1));
    applyStimulus("rpend4", mk(0, 0, BR_NONE, 0, 0, 0, 0, 1, 32'h3004, 1, 1));

    // Randomized traffic against the reference model, with occasional async resets.
    reset_n = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    m_pc = 32'h3000; m_run = 1'b0; m_due.delete();
    for (int c = 0; c < 600; c++) begin
      r_stall = ($urandom_range(0, 4) == 0);
      r_ready = ($urandom_range(0, 9) < 7);
      r_valid = ($urandom_range(0, 3) != 0);
      r_type  = 2'($urandom_range(0, 3));
      r_taken = $urandom_range(0, 1) == 1;
      r16 = rand_target(); r26 = rand_target(); rrs = rand_target();
      drive(mk(r_stall, r_valid, r_type, r_taken, r16, r26, rrs, r_ready, 0, 0, 0));
      if ($urandom_range(0, 63) == 0) begin
        #2 reset_n = 1'b0;
        #1 checkOutput("rnd_reset", 32'h3000, 1'b0, 1'b0);
        m_pc = 32'h3000; m_run = 1'b0; m_due.delete();
        @(negedge clk);
        reset_n = 1'b1;
        continue;
      end
      #1;
      done = m_run && r_ready && !r_stall;
      checkOutput($sformatf("rnd%0d", c), m_pc, m_run, done);
      if (!m_run) begin
        m_run = 1'b1;
      end else begin
        tgt = (r_type == BR_J) ? r26 : (r_type == BR_JR) ? rrs : r16;
        if (r_valid && !r_stall && m_due.size() == 0 &&
            (r_type == BR_J || r_type == BR_JR || (r_type == BR_BR && r_taken)))
          m_due.push_back(tgt);
        if (done) m_pc = (m_due.size() != 0) ? m_due.pop_front() : m_pc + 32'd4;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
